// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: converter FSM states, exponent constants
// and the RISC-V rounding-mode encodings.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } cvt_state_t;

    localparam int unsigned FP_BIAS      = 127;
    localparam logic [7:0]  CVT_EXP_INIT = 8'd158;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

endpackage

// File: rtl/fcvt_rounder.sv
// Combinational rounder for a normalised magnitude (bit 31 implied one).
// Produces the 23-bit mantissa, the exponent carry and the inexact flag.
module fcvt_rounder
    import fpu_pkg::*;
(
    input  logic [30:0] mag,
    input  logic        sign,
    input  logic [2:0]  rm,
    output logic [22:0] mant,
    output logic        exp_inc,
    output logic        inexact
);

    logic [22:0] trunc;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic [23:0] sum;

    assign trunc   = mag[30:8];
    assign guard   = mag[7];
    assign sticky  = |mag[6:0];
    assign inexact = guard | sticky;

    // Unlisted encodings fall back to round-to-nearest-even.
    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = (guard | sticky) & sign;
            RM_RUP:  inc = (guard | sticky) & ~sign;
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | trunc[0]);
        endcase
    end

    // A carry out of the mantissa leaves the low 23 bits at zero.
    assign sum     = {1'b0, trunc} + {23'd0, inc};
    assign mant    = sum[22:0];
    assign exp_inc = sum[23];

endmodule

// File: rtl/int_to_float_converter.sv
// 32-bit signed/unsigned integer to IEEE-754 single converter (FCVT.S.W/WU).
// Define FCVT_ROUNDING_MODES_EN to add the IN_RM rounding-mode port.
module int_to_float_converter
    import fpu_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_INT,
    input  logic        IN_SIGNED,
`ifdef FCVT_ROUNDING_MODES_EN
    input  logic [2:0]  IN_RM,
`endif
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_FLOAT,
    output logic        OUT_INEXACT
);

    cvt_state_t  state;
    logic        sign_r;
    logic [31:0] mag_r;
    logic [7:0]  exp_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [31:0] out_float_r;
    logic        out_inexact_r;

    logic        in_neg;
    logic [31:0] in_mag;
    logic [2:0]  rm_sel;
    logic [22:0] rnd_mant;
    logic        rnd_exp_inc;
    logic        rnd_inexact;

    assign in_neg = IN_SIGNED & IN_INT[31];
    assign in_mag = in_neg ? (~IN_INT + 32'd1) : IN_INT;

`ifdef FCVT_ROUNDING_MODES_EN
    logic [2:0] rm_r;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rm_r <= '0;
        end else if (state == IDLE && IN_VALID && in_ready_r) begin
            rm_r <= IN_RM;
        end
    end

    assign rm_sel = rm_r;
`else
    assign rm_sel = RM_RNE;
`endif

    fcvt_rounder u_rounder (
        .mag     (mag_r[30:0]),
        .sign    (sign_r),
        .rm      (rm_sel),
        .mant    (rnd_mant),
        .exp_inc (rnd_exp_inc),
        .inexact (rnd_inexact)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            sign_r        <= 1'b0;
            mag_r         <= '0;
            exp_r         <= '0;
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            out_float_r   <= '0;
            out_inexact_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID && in_ready_r) begin
                        sign_r     <= in_neg;
                        mag_r      <= in_mag;
                        exp_r      <= CVT_EXP_INIT;
                        in_ready_r <= 1'b0;
                        if (in_mag == '0) begin
                            out_float_r   <= '0;
                            out_inexact_r <= 1'b0;
                            out_valid_r   <= 1'b1;
                            state         <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                // Coarse shifts first, then single-bit steps until bit 31 is set.
                NORM: begin
                    if (mag_r[31 -: SHIFT_STEP] == '0) begin
                        mag_r <= mag_r << SHIFT_STEP;
                        exp_r <= exp_r - 8'(SHIFT_STEP);
                    end else if (!mag_r[31]) begin
                        mag_r <= mag_r << 1;
                        exp_r <= exp_r - 8'd1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out_float_r   <= {sign_r, exp_r + {7'd0, rnd_exp_inc}, rnd_mant};
                    out_inexact_r <= rnd_inexact;
                    out_valid_r   <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign IN_READY    = in_ready_r;
    assign OUT_VALID   = out_valid_r;
    assign OUT_FLOAT   = out_float_r;
    assign OUT_INEXACT = out_inexact_r;

endmodule

// File: tb/tb_int_to_float_converter.sv
// Directed scoreboard bench for int_to_float_converter; also exercises IN_RM
// when FCVT_ROUNDING_MODES_EN is defined.
module tb_int_to_float_converter;

    localparam int unsigned SS = 4;

    typedef struct {
        logic [31:0] f;
        logic        nx;
        int          lat;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_INT;
    logic        IN_SIGNED;
    logic [2:0]  IN_RM;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_FLOAT;
    logic        OUT_INEXACT;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    int_to_float_converter #(.SHIFT_STEP(SS)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_INT      (IN_INT),
        .IN_SIGNED   (IN_SIGNED),
`ifdef FCVT_ROUNDING_MODES_EN
        .IN_RM       (IN_RM),
`endif
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_FLOAT   (OUT_FLOAT),
        .OUT_INEXACT (OUT_INEXACT)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Reference conversion computed directly from the leading-zero count.
    function automatic exp_t model(input logic [31:0] v, input logic sg, input logic [2:0] rm);
        exp_t        r;
        logic        s;
        logic [31:0] m;
        logic [31:0] n;
        logic [23:0] sum;
        logic        g;
        logic        st;
        logic        inc;
        int          lz;
        logic [7:0]  e;
        s  = sg & v[31];
        m  = s ? (0 - v) : v;
        if (m == 0) begin
            r.f = 0; r.nx = 0; r.lat = 1;
            return r;
        end
        lz = 0;
        while (m[31 - lz] == 1'b0) lz++;
        n  = m << lz;
        g  = n[7];
        st = |n[6:0];
        case (rm)
            3'b001:  inc = 0;
            3'b010:  inc = (g | st) & s;
            3'b011:  inc = (g | st) & ~s;
            3'b100:  inc = g;
            default: inc = g & (st | n[8]);
        endcase
        sum   = {1'b0, n[30:8]} + {23'd0, inc};
        e     = 8'(158 - lz) + {7'd0, sum[23]};
        r.f   = {s, e, sum[22:0]};
        r.nx  = g | st;
        r.lat = 2 + lz / SS + lz % SS + 1;
        return r;
    endfunction

    // Called at a negedge; returns at a negedge after the output handshake.
    task automatic convert(input logic [31:0] v, input logic sg, input logic [2:0] rm,
                           input exp_t want, input int hold, input string tag);
        exp_t got_exp;
        int   cyc;
        logic [31:0] f0;
        cyc = 0;
        while (IN_READY !== 1'b1 && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        chk({tag, "_in_ready"}, {31'd0, IN_READY}, 32'd1);
        IN_INT    = v;
        IN_SIGNED = sg;
        IN_RM     = rm;
        IN_VALID  = 1'b1;
        sb.push_back(want);
        @(posedge CLK);
        #1;
        IN_VALID  = 1'b0;
        IN_INT    = $urandom;
        IN_SIGNED = ~sg;
        IN_RM     = 3'b001;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (OUT_VALID !== 1'b1 && cyc < 100);
        got_exp = sb.pop_front();
        chk({tag, "_latency"}, cyc, got_exp.lat);
        chk({tag, "_float"}, OUT_FLOAT, got_exp.f);
        chk({tag, "_inexact"}, {31'd0, OUT_INEXACT}, {31'd0, got_exp.nx});
        f0 = OUT_FLOAT;
        for (int h = 0; h < hold; h++) begin
            IN_VALID = 1'b1;
            @(negedge CLK);
            chk({tag, "_hold_valid"}, {31'd0, OUT_VALID}, 32'd1);
            chk({tag, "_hold_float"}, OUT_FLOAT, f0);
            chk({tag, "_hold_in_ready"}, {31'd0, IN_READY}, 32'd0);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        @(negedge CLK);
        chk({tag, "_valid_drop"}, {31'd0, OUT_VALID}, 32'd0);
    endtask

    task automatic plan(input logic [31:0] v, input logic sg, input logic [31:0] f,
                        input logic nx, input int lat, input string tag);
        exp_t e;
        e.f = f; e.nx = nx; e.lat = lat;
        convert(v, sg, 3'b000, e, 0, tag);
    endtask

    initial begin
        logic [31:0] rv;
        logic        rs;
        exp_t        e;
        int          cyc;
        RESET_N   = 1'b0;
        IN_VALID  = 1'b0;
        IN_INT    = '0;
        IN_SIGNED = 1'b0;
        IN_RM     = 3'b000;
        OUT_READY = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_in_ready", {31'd0, IN_READY}, 32'd0);
        chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_out_float", OUT_FLOAT, 32'd0);
        chk("rst_inexact", {31'd0, OUT_INEXACT}, 32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_in_ready", {31'd0, IN_READY}, 32'd1);

        plan(32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0, 13, "s_one");
        plan(32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 3,  "s_min");
        plan(32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0, 3,  "u_msb");
        plan(32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 3,  "u_max");
        plan(32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 13, "s_neg1");
        plan(32'h0100_0001, 1'b1, 32'h4B80_0000, 1'b1, 7,  "tie_even");
        plan(32'h0100_0003, 1'b1, 32'h4B80_0002, 1'b1, 7,  "tie_up");
        plan(32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1,  "zero");

        e.f = 32'h4B80_0002; e.nx = 1'b1; e.lat = 7;
        convert(32'h0100_0003, 1'b0, 3'b000, e, 5, "stall");

        for (int i = 0; i < 12; i++) begin
            rv = $urandom >> $urandom_range(0, 31);
            rs = 1'($urandom_range(0, 1));
            convert(rv, rs, 3'b000, model(rv, rs, 3'b000), 0, "rand");
        end

`ifdef FCVT_ROUNDING_MODES_EN
        plan(32'h0100_0001, 1'b1, 32'h4B80_0000, 1'b1, 7, "rne_ref");
        e.f = 32'h4B80_0001; e.nx = 1'b1; e.lat = 7;
        convert(32'h0100_0001, 1'b1, 3'b011, e, 0, "rup");
        e.f = 32'h4B80_0000;
        convert(32'h0100_0001, 1'b1, 3'b001, e, 0, "rtz");
        e.f = 32'hCB80_0001;
        convert(32'hFEFF_FFFF, 1'b1, 3'b010, e, 0, "rdn_neg");
        for (int i = 0; i < 8; i++) begin
            rv = $urandom;
            rs = 1'($urandom_range(0, 1));
            convert(rv, rs, 3'(i % 6), model(rv, rs, 3'(i % 6)), 0, "rand_rm");
        end
`endif

        // Reset during NORM discards the operation.
        IN_INT    = 32'h0000_0001;
        IN_SIGNED = 1'b0;
        IN_VALID  = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("midrst_out_float", OUT_FLOAT, 32'd0);
        chk("midrst_in_ready", {31'd0, IN_READY}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (OUT_VALID !== 1'b0) cyc++;
        end
        chk("midrst_no_spurious", cyc, 0);
        chk("midrst_in_ready_after", {31'd0, IN_READY}, 32'd1);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
